// File: rtl/tensor_scalar_add_collector_if.sv
// tensor_scalar_add_collector_if
//   Bundles the collector's issue-credit, adder and output-stream signals.
//   master : collector side (drives issue_ready, adder_float_sel, m_*, err)
//   slave  : environment side (upstream issuer, adder, downstream consumer)
// Signals:
//   req_float         requested adder mode (1 = float32, 0 = integer)
//   issue_valid       upstream presents an operand pair
//   issue_ready       issue permitted this cycle
//   adder_float_sel   adder float/int select
//   adder_out_valid   adder result valid
//   adder_out_result  adder result
//   m_valid/m_ready   output stream handshake
//   m_data            head-of-FIFO result
//   m_count           FIFO occupancy
//   err               sticky protocol error
interface tensor_scalar_add_collector_if #(
  parameter int unsigned BW_TENSOR_SCALAR = 32,
  parameter int unsigned DEPTH            = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                        req_float;
  logic                        issue_valid;
  logic                        issue_ready;
  logic                        adder_float_sel;
  logic                        adder_out_valid;
  logic [BW_TENSOR_SCALAR-1:0] adder_out_result;
  logic                        m_valid;
  logic                        m_ready;
  logic [BW_TENSOR_SCALAR-1:0] m_data;
  logic [CW-1:0]               m_count;
  logic                        err;

  modport master (
    input  req_float,
    input  issue_valid,
    output issue_ready,
    output adder_float_sel,
    input  adder_out_valid,
    input  adder_out_result,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_count,
    output err
  );

  modport slave (
    output req_float,
    output issue_valid,
    input  issue_ready,
    input  adder_float_sel,
    output adder_out_valid,
    output adder_out_result,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_count,
    input  err
  );
endinterface

// File: rtl/tensor_scalar_add_collector.sv
// tensor_scalar_add_collector
//   Collects the tensor-scalar adder's fixed-latency results into a small FIFO,
//   presents them as a ready/valid stream, grants upstream issue credits so the
//   FIFO never overflows, and owns the adder's int/float mode select, draining
//   the float pipeline before leaving float mode.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   io_bus  collector-side (master) view of tensor_scalar_add_collector_if
// Build option:
//   TENSOR_ADD_COLLECT_FLOAT_EN  defined enables the float mode (FLOAT/DRAIN
//   states, in-flight tracking). Undefined: integer-only, req_float ignored.
module tensor_scalar_add_collector #(
  parameter int unsigned BW_TENSOR_SCALAR = 32,
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned FLOAT_LATENCY    = 3
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  tensor_scalar_add_collector_if.master        io_bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(FLOAT_LATENCY + 1);

  typedef enum logic [1:0] {StInt, StFloat, StDrain} state_e;

  state_e                      r_state;
  state_e                      w_state_d;
  logic [BW_TENSOR_SCALAR-1:0] r_mem [DEPTH];
  logic [AW-1:0]               r_rd_ptr;
  logic [AW-1:0]               r_wr_ptr;
  logic [CW-1:0]               r_count;
  logic [IW-1:0]               r_inflight;
  logic [IW-1:0]               w_inflight_d;
  logic                        r_err;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_push_ok;
  logic w_fire;
  logic w_issue_ready;
  logic w_float_sel;
  logic w_spurious;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = (r_count != '0) && io_bus.m_ready;
  assign w_push    = io_bus.adder_out_valid;
  // A push into a full FIFO is only kept when the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_fire    = io_bus.issue_valid && w_issue_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StInt;
    end else begin
      r_state <= w_state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
`ifdef TENSOR_ADD_COLLECT_FLOAT_EN
    unique case (r_state)
      StInt: begin
        if (io_bus.req_float) w_state_d = StFloat;
      end
      StFloat: begin
        if (!io_bus.req_float) w_state_d = (r_inflight == '0) ? StInt : StDrain;
      end
      StDrain: begin
        // req_float may move freely while draining; it is only sampled here.
        if (r_inflight == '0) w_state_d = io_bus.req_float ? StFloat : StInt;
      end
      default: w_state_d = StInt;
    endcase
`else
    w_state_d = StInt;
`endif
  end

`ifndef TENSOR_ADD_COLLECT_FLOAT_EN
  logic w_unused_req_float;
  assign w_unused_req_float = io_bus.req_float;
`endif

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_issue_ready = 1'b0;
    w_float_sel   = 1'b0;
    unique case (r_state)
      StInt: begin
        w_issue_ready = (r_count < CW'(DEPTH));
      end
      StFloat: begin
        w_float_sel   = 1'b1;
        // Reserve a slot for every result still in the pipeline; a same-cycle
        // pop is deliberately not credited.
        w_issue_ready = ((32'(r_count) + 32'(r_inflight)) < DEPTH) &&
                        (32'(r_inflight) < FLOAT_LATENCY);
      end
      StDrain: begin
        w_float_sel = 1'b1;
      end
      default: ;
    endcase
    if (i_rst) w_issue_ready = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // In-flight float results
  // ---------------------------------------------------------------------------
  always_comb begin
    w_inflight_d = r_inflight;
    if ((r_state == StFloat) && w_fire) begin
      w_inflight_d = w_inflight_d + IW'(1);
    end
    if ((r_state != StInt) && w_push && (r_inflight != '0)) begin
      w_inflight_d = w_inflight_d - IW'(1);
    end
    if (w_state_d == StInt) w_inflight_d = '0;
  end

`ifdef TENSOR_ADD_COLLECT_FLOAT_EN
  // A float-mode result with nothing outstanding means the adder misbehaved.
  assign w_spurious = w_push && (r_state != StInt) && (r_inflight == '0);
`else
  assign w_spurious = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FIFO, counters and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= io_bus.adder_out_result;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= r_count + CW'(w_push_ok) - CW'(w_pop);
      r_inflight <= w_inflight_d;
      r_err      <= r_err | (w_push && w_full && !w_pop) | w_spurious;
    end
  end

  assign io_bus.issue_ready     = w_issue_ready;
  assign io_bus.adder_float_sel = w_float_sel;
  assign io_bus.m_valid         = (r_count != '0);
  assign io_bus.m_data          = r_mem[r_rd_ptr];
  assign io_bus.m_count         = r_count;
  assign io_bus.err             = r_err;

endmodule

// File: doc/tensor_scalar_add_collector.md
# tensor_scalar_add_collector

Result collector and issue-credit controller sitting directly downstream of the tensor-scalar adder stage. It is the only consumer of the adder's output valid/result pair. It turns the adder's fixed-latency output into a ready/valid stream through a small FIFO. It also grants upstream issue credits so the FIFO can never overflow. It owns the adder's integer/float mode select and drains the float pipeline before any mode switch.

## Interface
- BW_TENSOR_SCALAR, 32, scalar result width
- DEPTH, 4, result FIFO entries (power of two, ≥ FLOAT_LATENCY+1)
- FLOAT_LATENCY, 3, adder float-path latency in cycles (enable held high)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_float  in  1  requested adder mode (1 = float32, 0 = integer)
- issue_valid  in  1  upstream presents an operand pair to the adder
- issue_ready  out  1  issue permitted this cycle
- adder_float_sel  out  1  drives the adder's float/int select
- adder_out_valid  in  1  adder result valid
- adder_out_result  in  BW_TENSOR_SCALAR  adder result
- m_valid  out  1  collector output valid
- m_ready  in  1  consumer ready
- m_data  out  BW_TENSOR_SCALAR  head-of-FIFO result
- m_count  out  clog2(DEPTH+1)  FIFO occupancy
- err  out  1  sticky protocol error

## Operation
- States: INT, FLOAT, DRAIN. Reset state is INT.
- INT:
  - If req_float = 1, go to FLOAT next cycle.
  - adder_float_sel = 0.
- FLOAT:
  - If req_float = 0 and inflight = 0, go to INT.
  - If req_float = 0 and inflight > 0, go to DRAIN.
  - adder_float_sel = 1.
- DRAIN:
  - adder_float_sel = 1 and issue_ready = 0.
  - When inflight = 0, go to INT if req_float = 0, otherwise to FLOAT.
- inflight counter (0..FLOAT_LATENCY):
  - +1 on issue_valid && issue_ready in FLOAT.
  - −1 on adder_out_valid in FLOAT or DRAIN.
  - Increment and decrement in the same cycle leave it unchanged.
  - It is always 0 in INT.
- issue_ready:
  - INT: (m_count < DEPTH).
  - FLOAT: (m_count + inflight < DEPTH) && (inflight < FLOAT_LATENCY).
  - DRAIN: 0.
  - Always 0 during rst.
  - The credit check is conservative: a same-cycle pop does not add credit.
- Push: adder_out_valid writes adder_out_result at the tail. A push and a pop in the same cycle are both honoured.
- Pop: m_valid && m_ready advances the head.
- err is set and held until rst on any of these:
  - adder_out_valid with the FIFO full and no pop that cycle; the result is dropped.
  - adder_out_valid in FLOAT/DRAIN with inflight = 0; the result is still pushed.
  - req_float changing while in DRAIN is not an error; the new value is sampled at DRAIN exit.
- Pointers wrap modulo DEPTH. Occupancy is tracked separately, so full and empty are unambiguous.

## Timing
- Reset values:
  - issue_ready = 0, adder_float_sel = 0, m_valid = 0, m_data = 0, m_count = 0, err = 0.
  - inflight = 0, state = INT.
- The rst assertion mid-operation discards FIFO contents and in-flight tracking on the next edge. Adder results arriving during rst are ignored and do not set err.
- INT: the adder path is combinational, so adder_out_valid arrives in the issue cycle.
- FLOAT: the result arrives FLOAT_LATENCY cycles after issue.
- The adder's enable is tied high by the integrator. Credits alone guarantee no overflow.
- Push to m_valid latency is 1 cycle. m_data is the registered head.
- m_count updates on the edge after a push or pop.
- Mode change FLOAT→INT:
  - Takes 1 cycle when the pipeline is empty.
  - Otherwise takes as many cycles as the last in-flight result needs to emerge, plus 1.
- Mode change INT→FLOAT takes 1 cycle.

## Configuration
- TENSOR_ADD_COLLECT_FLOAT_EN:
  - Defined: behaviour as above.
  - Undefined:
    - req_float is ignored and the state is fixed at INT.
    - adder_float_sel = 0, inflight is held at 0 and absent from the credit equation.
    - The inflight = 0 err condition is removed.
  - This matches builds where the adder has no float pipeline.

## Test plan
- INT streaming: issue results 1,2,3,4,5 back-to-back with m_ready = 1.
  - m_data = 1..5 on consecutive cycles, each 1 cycle after its push.
  - m_count ≤ 1, err = 0.
- FLOAT credit limit: DEPTH = 4, m_ready = 0, issue_valid held high.
  - Exactly 3 issues are accepted, since inflight caps at 3, then 1 more after the first result lands.
  - m_count reaches 4 and issue_ready stays 0 until a pop.
- Mode drain: 2 float ops in flight, then req_float → 0.
  - State goes to DRAIN and issue_ready = 0 until both results arrive.
  - State reaches INT 1 cycle later and adder_float_sel falls.
- Simultaneous push/pop at full: m_count = 4, adder_out_valid and m_ready both high.
  - m_count stays 4, the new value lands at the tail, err = 0.
- Overflow/spurious: force adder_out_valid with m_count = 4 and m_ready = 0.
  - err = 1 and the value is dropped.
  - Then assert rst: err = 0, m_count = 0, m_valid = 0 next cycle.
- Macro off: toggle req_float.
  - adder_float_sel stays 0 and the INT streaming case passes unchanged.
